nand4_resp_checker: RTL and testbench

NAND4_RESP_CHECKER -- requirements
Module: nand4_resp_checker

---
 rtl/nand4_resp_checker_pkg.sv | 17 +
 rtl/nand4_misr16.sv | 21 ++
 rtl/nand4_resp_checker.sv | 110 +++++++++++
 tb/tb_nand4_resp_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nand4_resp_checker_pkg.sv
// rtl/nand4_resp_checker_pkg.sv - shared types, MISR constants and NAND4 reference for the checker
package nand4_resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic nand4_expect(input logic [3:0] a);
    return ~(a[3] & a[2] & a[1] & a[0]);
  endfunction

endpackage

// File: rtl/nand4_misr16.sv
// rtl/nand4_misr16.sv - 16-bit MISR compacting accepted {code, response} samples
module nand4_misr16
  import nand4_resp_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [4:0]  data,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {11'b0, data};
    end
  end

endmodule

// File: rtl/nand4_resp_checker.sv
// rtl/nand4_resp_checker.sv - run-based checker comparing observed NAND4 responses with the expected truth table
module nand4_resp_checker
  import nand4_resp_checker_pkg::*;
#(
  parameter int N_SAMPLES   = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic        in_y,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  err_cnt,
  output logic [15:0] cov_map,
  output logic [3:0]  first_err_a,
  output logic        first_err_vld,
  output logic [15:0] signature
);

  localparam logic [7:0] LAST_SAMPLE = 8'(N_SAMPLES - 1);
  localparam logic [7:0] LAST_IDLE   = 8'(TIMEOUT_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] sample_cnt;
  logic [7:0] idle_cnt;
  logic       accept;
  logic       take;
  logic       mismatch;
  logic       last_sample;
  logic       idle_hit;

  assign in_ready    = (state == ST_RUN);
  assign accept      = in_valid & in_ready;
  // A start pulse restarts the run and drops any sample offered in the same cycle.
  assign take        = accept & ~start;
  assign mismatch    = take & (in_y != nand4_expect(in_a));
  assign last_sample = (sample_cnt == LAST_SAMPLE);
  assign idle_hit    = (idle_cnt == LAST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (take && last_sample) begin
        state_nxt = ST_DONE;
      end else if (!accept && idle_hit) begin
        state_nxt = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      sample_cnt    <= 8'd0;
      idle_cnt      <= 8'd0;
      timeout       <= 1'b0;
      err_cnt       <= 8'd0;
      cov_map       <= 16'h0000;
      first_err_a   <= 4'h0;
      first_err_vld <= 1'b0;
    end else if (state == ST_RUN) begin
      if (accept) begin
        sample_cnt <= sample_cnt + 8'd1;
        idle_cnt   <= 8'd0;
        cov_map    <= cov_map | (16'h0001 << in_a);
        if (mismatch) begin
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
          if (!first_err_vld) begin
            first_err_a   <= in_a;
            first_err_vld <= 1'b1;
          end
        end
      end else begin
        idle_cnt <= idle_cnt + 8'd1;
        if (idle_hit) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  nand4_misr16 u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .en    (take),
    .data  ({in_a, in_y}),
    .sig   (signature)
  );

  assign done = (state == ST_DONE);
  assign pass = done & (err_cnt == 8'd0) & (cov_map == 16'hFFFF) & ~timeout;

endmodule

// File: tb/tb_nand4_resp_checker.sv
// tb/tb_nand4_resp_checker.sv - directed self-checking bench for nand4_resp_checker
module tb_nand4_resp_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_a = 4'h0;
  logic        in_y = 1'b0;
  logic        in_ready, done, pass, timeout, first_err_vld;
  logic [7:0]  err_cnt;
  logic [15:0] cov_map, signature;
  logic [3:0]  first_err_a;

  logic        start2 = 1'b0;
  logic        in_valid2 = 1'b0;
  logic [3:0]  in_a2 = 4'h0;
  logic        in_y2 = 1'b0;
  logic        in_ready2, done2, pass2, timeout2, first_err_vld2;
  logic [7:0]  err_cnt2;
  logic [15:0] cov_map2, signature2;
  logic [3:0]  first_err_a2;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_sig;
  logic [15:0] model_sig2;

  nand4_resp_checker dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_y(in_y), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .cov_map(cov_map), .first_err_a(first_err_a),
    .first_err_vld(first_err_vld), .signature(signature)
  );

  nand4_resp_checker #(.N_SAMPLES(255), .TIMEOUT_CYC(64)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_y(in_y2), .done(done2), .pass(pass2), .timeout(timeout2),
    .err_cnt(err_cnt2), .cov_map(cov_map2), .first_err_a(first_err_a2),
    .first_err_vld(first_err_vld2), .signature(signature2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] a, input logic y);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, a, y};
  endfunction

  task automatic send(input logic [3:0] a, input logic y);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_y     = y;
    @(posedge clk);
    #1;
    model_sig = misr_step(model_sig, a, y);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    model_sig = 16'hFFFF;
  endtask

  // mode 0: codes 0..15 twice, correct; mode 1: code 15 answered 1; mode 2: codes 0..7 four times
  task automatic run32(input int mode);
    for (int i = 0; i < 32; i++) begin
      logic [3:0] a;
      logic       y;
      a = (mode == 2) ? 4'(i % 8) : 4'(i % 16);
      y = (a != 4'hF);
      if (mode == 1 && a == 4'hF) y = 1'b1;
      send(a, y);
      if (i == 30) check("done_before_last", done, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_err_cnt"}, err_cnt, 8'd0);
    check({tag, "_cov_map"}, cov_map, 16'h0000);
    check({tag, "_first_err_a"}, first_err_a, 4'h0);
    check({tag, "_first_err_vld"}, first_err_vld, 1'b0);
    check({tag, "_signature"}, signature, 16'hFFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("rst");

    // full correct run
    pulse_start();
    check("run_in_ready", in_ready, 1'b1);
    check("run_sig_seed", signature, 16'hFFFF);
    run32(0);
    check("full_done", done, 1'b1);
    check("full_pass", pass, 1'b1);
    check("full_err", err_cnt, 8'd0);
    check("full_cov", cov_map, 16'hFFFF);
    check("full_sig", signature, model_sig);
    check("full_ready_low", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    check("full_sig_hold", signature, model_sig);
    check("full_done_hold", done, 1'b1);

    // code 15 answered wrong twice; start from DONE clears done/pass
    pulse_start();
    check("restart_done_clr", done, 1'b0);
    check("restart_pass_clr", pass, 1'b0);
    run32(1);
    check("err_done", done, 1'b1);
    check("err_cnt", err_cnt, 8'd2);
    check("err_first_a", first_err_a, 4'hF);
    check("err_first_vld", first_err_vld, 1'b1);
    check("err_pass", pass, 1'b0);
    check("err_sig", signature, model_sig);

    // timeout after 10 accepts
    pulse_start();
    for (int i = 0; i < 10; i++) send(4'(i), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("to_not_done_yet", done, 1'b0);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("to_idle_cycles", k, 64);
    check("to_timeout", timeout, 1'b1);
    check("to_done", done, 1'b1);
    check("to_pass", pass, 1'b0);
    check("to_cov", cov_map, 16'h03FF);
    check("to_err", err_cnt, 8'd0);

    // partial coverage
    pulse_start();
    run32(2);
    check("cov8_done", done, 1'b1);
    check("cov8_cov", cov_map, 16'h00FF);
    check("cov8_err", err_cnt, 8'd0);
    check("cov8_pass", pass, 1'b0);

    // start collides with an accept mid-run: sample dropped, run restarted
    pulse_start();
    for (int i = 0; i < 5; i++) send(4'(i), 1'b1);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_a     = 4'h5;
    in_y     = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("coll_cov", cov_map, 16'h0000);
    check("coll_err", err_cnt, 8'd0);
    check("coll_sig", signature, 16'hFFFF);
    check("coll_ready", in_ready, 1'b1);
    check("coll_done", done, 1'b0);

    // reset mid-run overriding start and accept
    model_sig = 16'hFFFF;
    for (int i = 0; i < 3; i++) send(4'hF, 1'b1);
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_a     = 4'h7;
    in_y     = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    check_reset_values("midrst");
    @(negedge clk);
    check("midrst_stay_idle", in_ready, 1'b0);

    // saturation with N_SAMPLES=255, every response wrong
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2     = 1'b0;
    model_sig2 = 16'hFFFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid2 = 1'b1;
      in_a2     = 4'(i % 16);
      in_y2     = (in_a2 == 4'hF);
      @(posedge clk);
      if (i < 255) model_sig2 = misr_step(model_sig2, 4'(i % 16), (4'(i % 16) == 4'hF));
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    check("sat_err", err_cnt2, 8'd255);
    check("sat_done", done2, 1'b1);
    check("sat_sig", signature2, model_sig2);
    check("sat_first_a", first_err_a2, 4'h0);
    check("sat_first_vld", first_err_vld2, 1'b1);
    check("sat_pass", pass2, 1'b0);
    check("sat_cov", cov_map2, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
